// File: rtl/signed_qformat_divider.sv
// Iterative signed Q-format divider (restoring, one quotient bit per clock).
// Operands and result share the same Q(NUM_FIXED_BITS).(NUM_FRACTIONAL_BITS)
// format. The result is truncated toward zero and saturated to MAX/MIN.
// Divide-by-zero skips the iteration and reports immediately.
module signed_qformat_divider #(
  parameter int NUM_FIXED_BITS      = 8,
  parameter int NUM_FRACTIONAL_BITS = 8
) (
  input  logic                                           i_clock,
  input  logic                                           i_reset,      // async, active-low
  input  logic                                           i_in_valid,
  output logic                                           o_in_ready,
  input  logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0]  i_dividend,
  input  logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0]  i_divisor,
  output logic                                           o_out_valid,
  input  logic                                           i_out_ready,
  output logic [NUM_FIXED_BITS+NUM_FRACTIONAL_BITS-1:0]  o_quotient,
  output logic                                           o_overflow,
  output logic                                           o_div_by_zero
);

  localparam int T     = NUM_FIXED_BITS + NUM_FRACTIONAL_BITS;
  localparam int F     = NUM_FRACTIONAL_BITS;
  localparam int ITER  = T + F;
  localparam int Q_W   = T + F;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);
  localparam logic [T-1:0]     MAX_Q     = {1'b0, {(T-1){1'b1}}};
  localparam logic [T-1:0]     MIN_Q     = {1'b1, {(T-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_sign;
  logic [Q_W-1:0]   r_num;       // numerator, consumed MSB first
  logic [T-1:0]     r_den;       // |divisor|, |MIN| fits as unsigned
  logic [T-1:0]     r_rem;       // partial remainder, always < r_den
  logic [Q_W-1:0]   r_q;         // quotient magnitude being built
  logic [CNT_W-1:0] r_cnt;
  logic [T-1:0]     r_quotient;
  logic             r_overflow;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_div_zero;
  logic [T-1:0]     w_abs_dividend;
  logic [T-1:0]     w_abs_divisor;
  logic [T:0]       w_rem_shift;
  logic [T:0]       w_rem_diff;
  logic             w_fits;
  logic [T-1:0]     w_rem_next;
  logic [Q_W-1:0]   w_q_next;
  logic             w_last;
  logic             w_pos_ovf;
  logic             w_neg_ovf;
  logic [T-1:0]     w_mag;
  logic [T-1:0]     w_final_q;
  logic             w_final_ovf;

  assign w_accept       = i_in_valid && (r_state == S_IDLE);
  assign w_div_zero     = (i_divisor == '0);
  assign w_abs_dividend = i_dividend[T-1] ? -i_dividend : i_dividend;
  assign w_abs_divisor  = i_divisor[T-1]  ? -i_divisor  : i_divisor;

  // One restoring step: the borrow out of the trial subtraction decides the bit.
  assign w_rem_shift = {r_rem, r_num[Q_W-1]};
  assign w_rem_diff  = w_rem_shift - {1'b0, r_den};
  assign w_fits      = ~w_rem_diff[T];
  assign w_rem_next  = w_fits ? w_rem_diff[T-1:0] : w_rem_shift[T-1:0];
  assign w_q_next    = {r_q[Q_W-2:0], w_fits};
  assign w_last      = (r_cnt == LAST_ITER);

  // Saturation: positive range tops out at 2^(T-1)-1, negative at 2^(T-1).
  assign w_pos_ovf   = |w_q_next[Q_W-1:T-1];
  assign w_neg_ovf   = (|w_q_next[Q_W-1:T]) || (w_q_next[T-1] && (|w_q_next[T-2:0]));
  assign w_mag       = w_q_next[T-1:0];
  assign w_final_q   = r_sign ? (w_neg_ovf ? MIN_Q : -w_mag)
                              : (w_pos_ovf ? MAX_Q : w_mag);
  assign w_final_ovf = r_sign ? w_neg_ovf : w_pos_ovf;

  assign o_quotient    = r_quotient;
  assign o_overflow    = r_overflow;
  assign o_div_by_zero = r_div_by_zero;

  // State register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_state_next = w_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sign        <= 1'b0;
      r_num         <= '0;
      r_den         <= '0;
      r_rem         <= '0;
      r_q           <= '0;
      r_cnt         <= '0;
      r_quotient    <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sign <= i_dividend[T-1] ^ i_divisor[T-1];
        r_num  <= {w_abs_dividend, {F{1'b0}}};
        r_den  <= w_abs_divisor;
        r_rem  <= '0;
        r_q    <= '0;
        r_cnt  <= '0;
        if (w_div_zero) begin
          r_quotient    <= i_dividend[T-1] ? MIN_Q : MAX_Q;
          r_overflow    <= 1'b0;
          r_div_by_zero <= 1'b1;
        end
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_next;
        r_num <= {r_num[Q_W-2:0], 1'b0};
        r_q   <= w_q_next;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_quotient    <= w_final_q;
          r_overflow    <= w_final_ovf;
          r_div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule
